lcd_frame_feeder: RTL

Upstream feeder for the character-LCD bus stage: it holds a 32-character frame buffer (2 lines × 16) written by game/scoreboard logic and streams the HD44780 power-on init sequence and full-screen refreshes as {RS, DATA} bytes over a valid/ready handshake. The downstream LCD bus stage turns each accepted byte into one enable strobe. Command-execution waits are enforced here, so the downstream stage never sees a byte before the panel can accept it.

---
 rtl/lcd_frame_feeder.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_frame_feeder.sv
// lcd_frame_feeder
// Holds a 2x16 character frame buffer and streams the HD44780 power-on init
// sequence followed by full-screen refreshes as {RS, DATA} bytes over a
// valid/ready handshake. Panel execution waits are enforced here, so the
// downstream bus stage can pulse the enable for every accepted byte.
//
// Ports:
//   CLOCK       system clock
//   ASYNC_RST   asynchronous active-low reset
//   WR_EN       frame-buffer write strobe
//   WR_ADDR     character slot (0-15 line 1, 16-31 line 2)
//   WR_CHAR     character code to store
//   OUT_VALID   byte presented downstream
//   OUT_READY   downstream accepts the byte
//   OUT_RS      0 = command, 1 = character
//   OUT_DATA    command or character code
//   BUSY        high during power wait, init or refresh
//   FRAME_DONE  one-cycle pulse after the last character of a refresh
//
// Build option: LCD_FEED_AUTO_REFRESH_EN adds a periodic refresh counter
// that marks the frame dirty every REFRESH_CYCLES cycles spent in IDLE.
//
// state      | meaning
// POWER_WAIT | panel power-up wait before the first command
// INIT       | function set, display on, entry mode, clear (init_idx 0-3)
// IDLE       | nothing to send; starts a refresh when dirty
// L1_ADDR    | DDRAM address 0x80 (line 1)
// L1_CHARS   | characters of slots 0-15
// L2_ADDR    | DDRAM address 0xC0 (line 2)
// L2_CHARS   | characters of slots 16-31
// Every byte state has a gap sub-phase: OUT_VALID low while wait_cnt runs.

module lcd_frame_feeder #(
  parameter int INIT_WAIT_CYCLES = 750000,
  parameter int CMD_GAP_CYCLES   = 2500,
  parameter int CLEAR_GAP_CYCLES = 82000,
  parameter int REFRESH_CYCLES   = 5000000
) (
  input  logic       CLOCK,
  input  logic       ASYNC_RST,
  input  logic       WR_EN,
  input  logic [4:0] WR_ADDR,
  input  logic [7:0] WR_CHAR,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic       OUT_RS,
  output logic [7:0] OUT_DATA,
  output logic       BUSY,
  output logic       FRAME_DONE
);

  localparam int T_MAX_A = (INIT_WAIT_CYCLES > CMD_GAP_CYCLES) ? INIT_WAIT_CYCLES : CMD_GAP_CYCLES;
  localparam int T_MAX   = (T_MAX_A > CLEAR_GAP_CYCLES) ? T_MAX_A : CLEAR_GAP_CYCLES;
  localparam int TW      = (T_MAX < 2) ? 1 : $clog2(T_MAX + 1);

  localparam logic [TW-1:0] INIT_LD  = TW'(INIT_WAIT_CYCLES);
  localparam logic [TW-1:0] CMD_LD   = TW'(CMD_GAP_CYCLES);
  localparam logic [TW-1:0] CLEAR_LD = TW'(CLEAR_GAP_CYCLES);
  localparam logic [TW-1:0] T_ONE    = TW'(1);

  typedef enum logic [2:0] {
    POWER_WAIT, INIT, IDLE, L1_ADDR, L1_CHARS, L2_ADDR, L2_CHARS
  } state_t;

  state_t        state, nxt_state;
  logic [1:0]    init_idx, nxt_init;
  logic [4:0]    slot, nxt_slot;
  logic [TW-1:0] wait_cnt, nxt_gap;
  logic          nxt_done;
  logic          dirty;
  logic [7:0]    fb [32];
  logic [8:0]    cur_byte, nxt_byte;

  function automatic logic [8:0] byte_of(input state_t s, input logic [1:0] idx,
                                         input logic [7:0] ch);
    logic [8:0] b;
    b = 9'h000;
    case (s)
      INIT: begin
        case (idx)
          2'd0:    b = 9'h038;
          2'd1:    b = 9'h00C;
          2'd2:    b = 9'h006;
          default: b = 9'h001;
        endcase
      end
      L1_ADDR:            b = 9'h080;
      L2_ADDR:            b = 9'h0C0;
      L1_CHARS, L2_CHARS: b = {1'b1, ch};
      default:            b = 9'h000;
    endcase
    return b;
  endfunction

  function automatic logic has_byte(input state_t s);
    return s inside {INIT, L1_ADDR, L1_CHARS, L2_ADDR, L2_CHARS};
  endfunction

  // Where the sequence goes after the byte currently on the bus is accepted.
  always_comb begin
    nxt_state = state;
    nxt_init  = init_idx;
    nxt_slot  = slot;
    nxt_gap   = CMD_LD;
    nxt_done  = 1'b0;
    case (state)
      INIT: begin
        if (init_idx == 2'd3) begin
          nxt_state = IDLE;
          nxt_gap   = CLEAR_LD;
        end else begin
          nxt_init = init_idx + 2'd1;
        end
      end
      L1_ADDR: begin
        nxt_state = L1_CHARS;
        nxt_slot  = 5'd0;
      end
      L1_CHARS: begin
        nxt_slot = slot + 5'd1;
        if (slot == 5'd15) nxt_state = L2_ADDR;
      end
      L2_ADDR: nxt_state = L2_CHARS;
      L2_CHARS: begin
        if (slot == 5'd31) begin
          nxt_state = IDLE;
          nxt_done  = 1'b1;
        end else begin
          nxt_slot = slot + 5'd1;
        end
      end
      default: ;
    endcase
  end

  // The buffer read here is the pre-edge contents, so a same-cycle write to
  // the slot being presented does not reach OUT_DATA.
  assign cur_byte = byte_of(state, init_idx, fb[slot]);
  assign nxt_byte = byte_of(nxt_state, nxt_init, fb[nxt_slot]);

`ifdef LCD_FEED_AUTO_REFRESH_EN
  localparam int RW = (REFRESH_CYCLES < 2) ? 1 : $clog2(REFRESH_CYCLES + 1);
  // Two cycles of the interval go to the IDLE->L1_ADDR hop and the
  // presentation edge, so 0x80 appears REFRESH_CYCLES after BUSY falls.
  localparam logic [RW-1:0] REFRESH_LD = RW'((REFRESH_CYCLES > 2) ? REFRESH_CYCLES - 2 : 1);
  localparam logic [RW-1:0] R_ONE      = RW'(1);
  logic [RW-1:0] refresh_cnt;
`else
  // Keeps the parameter referenced when the refresh counter is compiled out.
  logic unused_refresh;
  assign unused_refresh = (REFRESH_CYCLES != 0);
`endif

  always_ff @(posedge CLOCK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      for (int i = 0; i < 32; i++) fb[i] <= 8'h20;
      state      <= POWER_WAIT;
      init_idx   <= 2'd0;
      slot       <= 5'd0;
      wait_cnt   <= INIT_LD;
      dirty      <= 1'b1;
      OUT_VALID  <= 1'b0;
      OUT_RS     <= 1'b0;
      OUT_DATA   <= 8'h00;
      BUSY       <= 1'b1;
      FRAME_DONE <= 1'b0;
`ifdef LCD_FEED_AUTO_REFRESH_EN
      refresh_cnt <= REFRESH_LD;
`endif
    end else begin
      FRAME_DONE <= 1'b0;
      if (OUT_VALID && OUT_READY) begin
        state      <= nxt_state;
        init_idx   <= nxt_init;
        slot       <= nxt_slot;
        FRAME_DONE <= nxt_done;
        if (nxt_state == IDLE) BUSY <= dirty | WR_EN;
        // Zero gap: present the following byte on the same edge.
        if (nxt_gap == '0 && has_byte(nxt_state)) begin
          {OUT_RS, OUT_DATA} <= nxt_byte;
          wait_cnt           <= '0;
        end else begin
          OUT_VALID <= 1'b0;
          wait_cnt  <= nxt_gap;
        end
      end else if (!OUT_VALID) begin
        case (state)
          POWER_WAIT: begin
            if (wait_cnt <= T_ONE) begin
              state              <= INIT;
              init_idx           <= 2'd0;
              {OUT_RS, OUT_DATA} <= 9'h038;
              OUT_VALID          <= 1'b1;
              wait_cnt           <= '0;
            end else begin
              wait_cnt <= wait_cnt - T_ONE;
            end
          end
          IDLE: begin
            // The gap keeps running here so a refresh that starts right
            // away still honours the spacing after the previous byte.
            if (wait_cnt != '0) wait_cnt <= wait_cnt - T_ONE;
            if (dirty) begin
              state <= L1_ADDR;
              slot  <= 5'd0;
              BUSY  <= 1'b1;
              dirty <= 1'b0;
`ifdef LCD_FEED_AUTO_REFRESH_EN
              refresh_cnt <= REFRESH_LD;
`endif
            end
`ifdef LCD_FEED_AUTO_REFRESH_EN
            else if (refresh_cnt <= R_ONE) dirty <= 1'b1;
            else refresh_cnt <= refresh_cnt - R_ONE;
`endif
          end
          default: begin
            if (wait_cnt <= T_ONE) begin
              {OUT_RS, OUT_DATA} <= cur_byte;
              OUT_VALID          <= 1'b1;
              wait_cnt           <= '0;
            end else begin
              wait_cnt <= wait_cnt - T_ONE;
            end
          end
        endcase
      end
      // A write always wins over the IDLE clear so no update is lost.
      if (WR_EN) begin
        fb[WR_ADDR] <= WR_CHAR;
        dirty       <= 1'b1;
      end
    end
  end

endmodule
